// File: rtl/uart_rx_deserializer.sv
// UART receiver: rxd synchroniser, 16x-oversampled start/data/parity/stop capture, valid/ready output.
// Parity checking is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_deserializer #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rx_tick,
  input  logic                 rxd,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_BRK    = 3'd5
  } state_e;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  state_e                 state_q;
  logic [3:0]             tick_cnt_q;
  logic [2:0]             bit_cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   rx_valid_q;
  logic                   frame_err_q;
  logic                   overrun_q;
  logic                   mid_tick_s;
  logic                   frame_done_s;

`ifdef UART_RX_PARITY_EN
  logic par_en_q;
  logic par_odd_q;
  logic perr_q;
  logic parity_err_q;

  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data,
                                           input logic pbit, input logic odd);
    return ^{data, pbit, odd};
  endfunction
`else
  logic unused_parity_s;
  assign unused_parity_s = parity_en ^ parity_odd;
`endif

  assign rxd_s        = sync_q[SYNC_STAGES-1];
  assign mid_tick_s   = rx_tick && (tick_cnt_q == 4'd15);
  assign frame_done_s = mid_tick_s && (state_q == ST_STOP);

  // rxd synchroniser; idles high so reset does not look like a start bit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
  end

  // Frame FSM; only moves on rx_tick cycles
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= 4'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= '0;
`ifdef UART_RX_PARITY_EN
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_tick && !rxd_s) begin
            state_q    <= ST_START;
            tick_cnt_q <= 4'd0;
          end
        end
        ST_START: begin
          if (rx_tick) begin
            if (tick_cnt_q == 4'd7) begin
              tick_cnt_q <= 4'd0;
              bit_cnt_q  <= 3'd0;
              if (rxd_s) begin
                state_q <= ST_IDLE;
              end else begin
                state_q <= ST_DATA;
                shift_q <= '0;
`ifdef UART_RX_PARITY_EN
                par_en_q  <= parity_en;
                par_odd_q <= parity_odd;
                perr_q    <= 1'b0;
`endif
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (rx_tick) begin
            tick_cnt_q <= tick_cnt_q + 4'd1;
          end
          if (mid_tick_s) begin
            shift_q[bit_cnt_q] <= rxd_s;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= 3'd0;
`ifdef UART_RX_PARITY_EN
              state_q <= par_en_q ? ST_PARITY : ST_STOP;
`else
              state_q <= ST_STOP;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (rx_tick) begin
            tick_cnt_q <= tick_cnt_q + 4'd1;
          end
          if (mid_tick_s) begin
            perr_q  <= parity_mismatch(shift_q, rxd_s, par_odd_q);
            state_q <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (rx_tick) begin
            tick_cnt_q <= tick_cnt_q + 4'd1;
          end
          if (mid_tick_s) begin
            state_q <= rxd_s ? ST_IDLE : ST_BRK;
          end
        end
        ST_BRK: begin
          // Hold off until the line returns high so a break is not seen as a new start
          if (rx_tick && rxd_s) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= 4'd0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          tick_cnt_q <= 4'd0;
          bit_cnt_q  <= 3'd0;
        end
      endcase
    end
  end

  // Output holding register and valid/ready handshake; completion beats acceptance
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      overrun_q <= 1'b0;
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      if (frame_done_s) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q    <= shift_q;
          frame_err_q  <= !rxd_s;
`ifdef UART_RX_PARITY_EN
          parity_err_q <= perr_q;
`endif
          rx_valid_q   <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign rx_busy     = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: rx_tick every 4 clocks, so one bit lasts 64 clocks.
// Expectations for the parity scenario follow the UART_RX_PARITY_EN build setting.
module tb_uart_rx_deserializer;
  localparam int BIT_CLKS = 64;

  logic       clk;
  logic       resetn;
  logic       rx_tick;
  logic       rxd;
  logic       parity_en;
  logic       parity_odd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun_err;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;

  int         acc_cnt = 0;
  int         ovr_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_ferr = 1'b0;
  logic       last_perr = 1'b0;

  uart_rx_deserializer #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetn(resetn), .rx_tick(rx_tick), .rxd(rxd),
    .parity_en(parity_en), .parity_odd(parity_odd), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .parity_err(parity_err), .overrun_err(overrun_err), .rx_busy(rx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rx_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      rx_tick = 1'b1;
      @(negedge clk);
      rx_tick = 1'b0;
    end
  end

  // Records each accepted byte and every overrun pulse as the DUT sees them at the edge
  always @(posedge clk) begin
    if (rx_valid && rx_ready) begin
      acc_cnt   <= acc_cnt + 1;
      last_data <= rx_data;
      last_ferr <= frame_err;
      last_perr <= parity_err;
    end
    if (overrun_err) ovr_cnt <= ovr_cnt + 1;
  end

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit, input logic stopb);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (has_par) send_bit(pbit);
    send_bit(stopb);
    rxd = 1'b1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; rxd = 1'b1; rx_ready = 1'b1; parity_en = 1'b0; parity_odd = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rx_data); end
    checks++; if ({frame_err, parity_err, overrun_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {frame_err, parity_err, overrun_err}); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", rx_busy); end
    resetn = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", rx_busy); end
  endtask

  task automatic test_basic;
    int a0;
    a0 = acc_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    checks++; if (acc_cnt - a0 !== 1) begin errors++; $display("FAIL basic_count got %0d exp 1", acc_cnt - a0); end
    checks++; if (last_data !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", last_data); end
    checks++; if ({last_ferr, last_perr} !== 2'b00) begin errors++; $display("FAIL basic_flags got %b exp 00", {last_ferr, last_perr}); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b exp 0", rx_valid); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b exp 0", rx_busy); end
  endtask

  task automatic test_glitch;
    int a0;
    a0 = acc_cnt;
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy got %b exp 1", rx_busy); end
    rxd = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got %b exp 0", rx_busy); end
    checks++; if (acc_cnt - a0 !== 0) begin errors++; $display("FAIL glitch_count got %0d exp 0", acc_cnt - a0); end
  endtask

  task automatic test_parity;
    int   a0;
    logic exp_ferr;
    logic exp_perr_odd;
`ifdef UART_RX_PARITY_EN
    exp_ferr = 1'b0; exp_perr_odd = 1'b1;
`else
    exp_ferr = 1'b1; exp_perr_odd = 1'b0;
`endif
    parity_en = 1'b1;
    parity_odd = 1'b0;
    a0 = acc_cnt;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    checks++; if (acc_cnt - a0 !== 1) begin errors++; $display("FAIL par_even_count got %0d exp 1", acc_cnt - a0); end
    checks++; if (last_data !== 8'h3C) begin errors++; $display("FAIL par_even_data got %h exp 3c", last_data); end
    checks++; if ({last_ferr, last_perr} !== {exp_ferr, 1'b0}) begin errors++; $display("FAIL par_even_flags got %b exp %b", {last_ferr, last_perr}, {exp_ferr, 1'b0}); end
    parity_odd = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    checks++; if (acc_cnt - a0 !== 2) begin errors++; $display("FAIL par_odd_count got %0d exp 2", acc_cnt - a0); end
    checks++; if ({last_ferr, last_perr} !== {exp_ferr, exp_perr_odd}) begin errors++; $display("FAIL par_odd_flags got %b exp %b", {last_ferr, last_perr}, {exp_ferr, exp_perr_odd}); end
    parity_en = 1'b0;
    parity_odd = 1'b0;
  endtask

  task automatic test_break;
    int a0;
    a0 = acc_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i[0]);
    rxd = 1'b0;
    repeat (20 * BIT_CLKS) @(negedge clk);
    checks++; if (acc_cnt - a0 !== 1) begin errors++; $display("FAIL brk_count got %0d exp 1", acc_cnt - a0); end
    checks++; if (last_data !== 8'hAA) begin errors++; $display("FAIL brk_data got %h exp aa", last_data); end
    checks++; if (last_ferr !== 1'b1) begin errors++; $display("FAIL brk_ferr got %b exp 1", last_ferr); end
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL brk_wait got %b exp 1", rx_busy); end
    rxd = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL brk_release got %b exp 0", rx_busy); end
    checks++; if (acc_cnt - a0 !== 1) begin errors++; $display("FAIL brk_no_second got %0d exp 1", acc_cnt - a0); end
  endtask

  task automatic test_overrun;
    int a0;
    int o0;
    a0 = acc_cnt;
    o0 = ovr_cnt;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    checks++; if ({rx_valid, rx_data} !== {1'b1, 8'h11}) begin errors++; $display("FAIL ovr_first got %b/%h exp 1/11", rx_valid, rx_data); end
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulses got %0d exp 1", ovr_cnt - o0); end
    checks++; if ({rx_valid, rx_data} !== {1'b1, 8'h11}) begin errors++; $display("FAIL ovr_held got %b/%h exp 1/11", rx_valid, rx_data); end
    rx_ready = 1'b1;
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got %b exp 0", rx_valid); end
    checks++; if ({acc_cnt - a0, last_data} !== {32'd1, 8'h11}) begin errors++; $display("FAIL ovr_accept got %0d/%h exp 1/11", acc_cnt - a0, last_data); end
  endtask

  task automatic test_back_to_back;
    int a0;
    a0 = acc_cnt;
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    checks++; if ({acc_cnt - a0, last_data} !== {32'd1, 8'h00}) begin errors++; $display("FAIL b2b_first got %0d/%h exp 1/00", acc_cnt - a0, last_data); end
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    checks++; if ({acc_cnt - a0, last_data} !== {32'd2, 8'hFF}) begin errors++; $display("FAIL b2b_second got %0d/%h exp 2/ff", acc_cnt - a0, last_data); end
  endtask

  task automatic test_reset_midframe;
    int a0;
    rx_ready = 1'b0;
    send_frame(8'h33, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    rxd = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    checks++; if ({rx_busy, rx_valid} !== 2'b11) begin errors++; $display("FAIL rstmid_pre got %b exp 11", {rx_busy, rx_valid}); end
    #3 resetn = 1'b0;
    #1;
    checks++; if ({rx_valid, rx_data, frame_err, parity_err, overrun_err, rx_busy} !== 13'd0) begin errors++; $display("FAIL rstmid_outputs got %b exp 0", {rx_valid, rx_data, frame_err, parity_err, overrun_err, rx_busy}); end
    @(negedge clk);
    resetn = 1'b1;
    rx_ready = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    a0 = acc_cnt;
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    checks++; if ({acc_cnt - a0, last_data, last_ferr} !== {32'd1, 8'h81, 1'b0}) begin errors++; $display("FAIL rstmid_next got %0d/%h/%b exp 1/81/0", acc_cnt - a0, last_data, last_ferr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_break();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
